seven_segment_to_binary: RTL and testbench

//  Receive-side counterpart of the binary-to-7-segment path. It samples the

---
 rtl/seven_segment_to_binary.sv | 125 ++++++++++++
 tb/tb_seven_segment_to_binary.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_to_binary.sv
// Samples active-low 7-segment pad lines, debounces them and decodes each
// newly accepted pattern back to a 4-bit hex value with a one-cycle strobe.
module seven_segment_to_binary #(
    parameter int unsigned STABLE_CYCLES = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Segment_A,
    input  logic       i_Segment_B,
    input  logic       i_Segment_C,
    input  logic       i_Segment_D,
    input  logic       i_Segment_E,
    input  logic       i_Segment_F,
    input  logic       i_Segment_G,
    output logic [3:0] o_Binary_Num,
    output logic       o_Valid,
    output logic       o_Error,
    output logic       o_Blank,
    output logic [7:0] o_Update_Count
);

    localparam int unsigned CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic {
        LOCKED,
        SETTLE
    } state_t;

    state_t           state;
    logic [6:0]       pins;
    logic [6:0]       sync1;
    logic [6:0]       sync2;
    logic [6:0]       candidate;
    logic [6:0]       committed;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       decoded;

    // Active-high pattern, segment A in the MSB.
    assign pins = ~{i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                    i_Segment_E, i_Segment_F, i_Segment_G};

    // Returns {legal, value}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h7E:   decode = {1'b1, 4'h0};
            7'h30:   decode = {1'b1, 4'h1};
            7'h6D:   decode = {1'b1, 4'h2};
            7'h79:   decode = {1'b1, 4'h3};
            7'h33:   decode = {1'b1, 4'h4};
            7'h5B:   decode = {1'b1, 4'h5};
            7'h5F:   decode = {1'b1, 4'h6};
            7'h70:   decode = {1'b1, 4'h7};
            7'h7F:   decode = {1'b1, 4'h8};
            7'h7B:   decode = {1'b1, 4'h9};
            7'h77:   decode = {1'b1, 4'hA};
            7'h1F:   decode = {1'b1, 4'hB};
            7'h4E:   decode = {1'b1, 4'hC};
            7'h3D:   decode = {1'b1, 4'hD};
            7'h4F:   decode = {1'b1, 4'hE};
            7'h47:   decode = {1'b1, 4'hF};
            default: decode = '0;
        endcase
    endfunction

    assign decoded = decode(candidate);

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sync1          <= '0;
            sync2          <= '0;
            candidate      <= '0;
            committed      <= '0;
            cnt            <= '0;
            state          <= LOCKED;
            o_Binary_Num   <= '0;
            o_Valid        <= 1'b0;
            o_Error        <= 1'b0;
            o_Blank        <= 1'b1;
            o_Update_Count <= '0;
        end else begin
            sync1   <= pins;
            sync2   <= sync1;
            o_Valid <= 1'b0;
            case (state)
                LOCKED: begin
                    if (sync2 != candidate) begin
                        candidate <= sync2;
                        cnt       <= CNT_W'(1);
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (sync2 != candidate) begin
                        candidate <= sync2;
                        cnt       <= CNT_W'(1);
                    end else if (cnt < CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        state <= LOCKED;
                        // A glitch that settled back on the committed value is ignored.
                        if (candidate != committed) begin
                            committed <= candidate;
                            if (decoded[4]) begin
                                o_Binary_Num   <= decoded[3:0];
                                o_Valid        <= 1'b1;
                                o_Error        <= 1'b0;
                                o_Blank        <= 1'b0;
                                o_Update_Count <= o_Update_Count + 8'd1;
                            end else if (candidate == '0) begin
                                o_Blank <= 1'b1;
                                o_Error <= 1'b0;
                            end else begin
                                o_Error <= 1'b1;
                                o_Blank <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= LOCKED;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_segment_to_binary.sv
// Directed and randomized checks of seven_segment_to_binary against a
// run-length reference model of the accept/decode rules.
module tb_seven_segment_to_binary;

    localparam int unsigned STABLE = 4;

    logic       clk;
    logic       rst;
    logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
    logic [3:0] binary_num;
    logic       valid;
    logic       error;
    logic       blank;
    logic [7:0] update_count;

    seven_segment_to_binary #(.STABLE_CYCLES(STABLE)) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_Segment_A    (seg_a),
        .i_Segment_B    (seg_b),
        .i_Segment_C    (seg_c),
        .i_Segment_D    (seg_d),
        .i_Segment_E    (seg_e),
        .i_Segment_F    (seg_f),
        .i_Segment_G    (seg_g),
        .o_Binary_Num   (binary_num),
        .o_Valid        (valid),
        .o_Error        (error),
        .o_Blank        (blank),
        .o_Update_Count (update_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned strobes  = 0;
    logic        prev_valid = 1'b0;

    // Reference model state: pin history, run length of the synchronized value.
    logic [6:0]  h1, h2, prev_s, m_committed;
    int unsigned runlen;
    logic [3:0]  m_num;
    logic        m_valid, m_err, m_blank;
    logic [7:0]  m_cnt;

    function automatic int glyph_index(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (glyph[i] == p) return i;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        h1 = '0; h2 = '0; prev_s = '0; m_committed = '0; runlen = 0;
        m_num = '0; m_valid = 1'b0; m_err = 1'b0; m_blank = 1'b1; m_cnt = '0;
    endtask

    task automatic model_edge();
        logic [6:0] s;
        int         idx;
        if (rst) begin
            model_reset();
            return;
        end
        s  = h2;
        h2 = h1;
        h1 = ~{seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
        m_valid = 1'b0;
        if (s != prev_s) runlen = 1;
        else if (runlen != 0) runlen++;
        prev_s = s;
        if (runlen == STABLE + 1 && s != m_committed) begin
            m_committed = s;
            idx = glyph_index(s);
            if (idx >= 0) begin
                m_num = 4'(idx); m_valid = 1'b1; m_err = 1'b0; m_blank = 1'b0; m_cnt++;
            end else if (s == 7'h00) begin
                m_blank = 1'b1; m_err = 1'b0;
            end else begin
                m_err = 1'b1; m_blank = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        @(negedge clk);
        check("num",   32'(binary_num),   32'(m_num));
        check("valid", 32'(valid),        32'(m_valid));
        check("error", 32'(error),        32'(m_err));
        check("blank", 32'(blank),        32'(m_blank));
        check("count", 32'(update_count), 32'(m_cnt));
        if (valid && prev_valid) check("valid_spacing", 32'(1), 32'(0));
        prev_valid = valid;
        if (valid) strobes++;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic [6:0] p);
        {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = ~p;
    endtask

    task automatic do_reset(input int unsigned n);
        rst = 1'b1;
        model_reset();
        ticks(n);
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] p;
        int unsigned sel;

        // 1: reset, pins blank
        rst = 1'b1;
        drive(7'h00);
        model_reset();
        ticks(2);
        rst = 1'b0;
        strobes = 0;
        ticks(50);
        check("t1_strobes", strobes, 0);
        check("t1_blank", 32'(blank), 1);
        check("t1_count", 32'(update_count), 0);

        // 2: '7', strobe exactly at edge 7
        drive(glyph[7]);
        strobes = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("t2_valid_edge", 32'(valid), (k == 7) ? 1 : 0);
        end
        check("t2_strobes", strobes, 1);
        check("t2_num", 32'(binary_num), 7);
        check("t2_blank", 32'(blank), 0);
        check("t2_count", 32'(update_count), 1);

        // 3: short glitch to '8' and back
        strobes = 0;
        drive(glyph[8]);
        ticks(3);
        drive(glyph[7]);
        ticks(12);
        check("t3_strobes", strobes, 0);
        check("t3_num", 32'(binary_num), 7);
        check("t3_count", 32'(update_count), 1);

        // 4: illegal pattern, then '3'
        drive(7'h40);
        ticks(10);
        check("t4_error", 32'(error), 1);
        check("t4_num", 32'(binary_num), 7);
        check("t4_count", 32'(update_count), 1);
        strobes = 0;
        drive(glyph[3]);
        ticks(10);
        check("t4_strobes", strobes, 1);
        check("t4_num3", 32'(binary_num), 3);
        check("t4_error_clr", 32'(error), 0);

        // 5: sweep 0..F
        strobes = 0;
        for (int v = 0; v < 16; v++) begin
            drive(glyph[v]);
            ticks(10);
            check("t5_sweep_num", 32'(binary_num), 32'(v));
        end
        check("t5_sweep_strobes", strobes, 16);

        // 5b: count wrap over 256 commits from reset
        drive(7'h00);
        do_reset(2);
        ticks(3);
        strobes = 0;
        for (int n = 0; n < 256; n++) begin
            drive(glyph[n % 2]);
            ticks(10);
            if (n == 254) check("t5_count_255", 32'(update_count), 255);
        end
        check("t5_wrap_strobes", strobes, 256);
        check("t5_wrap_count", 32'(update_count), 0);

        // random patterns with random hold times
        for (int n = 0; n < 120; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 70) p = glyph[$urandom_range(0, 15)];
            else if (sel < 85) p = 7'h00;
            else begin
                p = 7'($urandom);
                while (p == 7'h00 || glyph_index(p) >= 0) p = 7'($urandom);
            end
            drive(p);
            ticks($urandom_range(1, 10));
        end
        ticks(10);

        // 6: reset mid-settle with '5' held
        drive(7'h00);
        do_reset(2);
        ticks(10);
        drive(glyph[5]);
        ticks(3);
        rst = 1'b1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t6_rst_num", 32'(binary_num), 0);
            check("t6_rst_valid", 32'(valid), 0);
            check("t6_rst_error", 32'(error), 0);
            check("t6_rst_blank", 32'(blank), 1);
            check("t6_rst_count", 32'(update_count), 0);
        end
        rst = 1'b0;
        strobes = 0;
        ticks(20);
        check("t6_strobes", strobes, 1);
        check("t6_num", 32'(binary_num), 5);
        check("t6_count", 32'(update_count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
